// File: rtl/apb_master_if.sv
// Bundle of the local command/response port and the APB4 requester signals.
// The master modport is the apb_master view; the slave modport is the view of
// whatever drives commands and answers on APB (controller plus responder).
interface apb_master_if #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32
);
    // local command port
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [ADDR_SIZE-1:0] cmd_addr;
    logic [DATA_SIZE-1:0] cmd_wdata;
    logic [3:0]           cmd_strb;
    logic [2:0]           cmd_prot;

    // APB4 bus
    logic [ADDR_SIZE-1:0] PADDR;
    logic [2:0]           PPROT;
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [DATA_SIZE-1:0] PWDATA;
    logic [3:0]           PSTRB;
    logic [DATA_SIZE-1:0] PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    // response strobe
    logic                 rsp_valid;
    logic [DATA_SIZE-1:0] rsp_rdata;
    logic                 rsp_slverr;
    logic                 rsp_timeout;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout
    );
endinterface

// File: rtl/apb_master.sv
// APB4 requester: accepts single-beat commands on a valid/ready port, runs one
// SETUP/ACCESS transfer per command and reports the outcome on a one-cycle
// response strobe. A wait-state counter aborts transfers to hung slaves.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_IDLE   | ready for a command; misaligned commands are answered from here
// ST_SETUP  | APB setup phase, PSEL=1 PENABLE=0, always one cycle
// ST_ACCESS | APB access phase, PSEL=1 PENABLE=1, waits for PREADY or timeout
module apb_master #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int TIMEOUT   = 255
) (
    input logic         PCLK,
    input logic         PRESET,
    apb_master_if.master bus
);

    // Counter holds 0..TIMEOUT; a disabled timeout still needs a legal 1-bit vector.
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = (TIMEOUT < 1) ? '1 : WAIT_W'(TIMEOUT);
    // The abort fires in the TIMEOUT-th wait cycle, i.e. when TIMEOUT-1 waits
    // have already been counted.
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT < 1) ? '0 : WAIT_W'(TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ADDR_SIZE-1:0] r_paddr;
    logic [2:0]           r_pprot;
    logic                 r_pwrite;
    logic [DATA_SIZE-1:0] r_pwdata;
    logic [3:0]           r_pstrb;

    logic [WAIT_W-1:0]    r_wait_cnt;

    logic                 r_rsp_valid;
    logic [DATA_SIZE-1:0] r_rsp_rdata;
    logic                 r_rsp_slverr;
    logic                 r_rsp_timeout;

    logic                 w_cmd_ready;
    logic                 w_psel;
    logic                 w_penable;
    logic                 w_accept;
    logic                 w_misalign;
    logic                 w_done;
    logic                 w_abort;
    logic                 w_aligned;
    logic                 w_wait_hit;

    assign w_aligned  = (bus.cmd_addr[1:0] == 2'b00);
    assign w_wait_hit = TIMEOUT_EN && (r_wait_cnt == WAIT_LAST);

    // State register; reset always lands in IDLE, abandoning any transfer.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and phase decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_accept    = 1'b0;
        w_misalign  = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (w_aligned) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_misalign  = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                w_psel      = 1'b1;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (bus.PREADY) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_wait_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the accepted command; these registers drive the APB address
    // phase for the whole transfer. Reads present zero data and strobes.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_paddr  <= '0;
            r_pprot  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else if (w_accept) begin
            r_paddr  <= bus.cmd_addr;
            r_pprot  <= bus.cmd_prot;
            r_pwrite <= bus.cmd_write;
            r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
            r_pstrb  <= bus.cmd_write ? bus.cmd_strb  : 4'b0000;
        end
    end

    // Count ACCESS cycles with PREADY low; cleared on the way into SETUP and
    // saturating so a disabled timeout cannot wrap back to zero.
    always_ff @(posedge PCLK) begin
        if (PRESET || w_accept) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !bus.PREADY && (r_wait_cnt != WAIT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Response strobe one cycle after completion; payload holds until the next one.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= w_done || w_abort || w_misalign;
            if (w_done) begin
                r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
                r_rsp_slverr  <= bus.PSLVERR;
                r_rsp_timeout <= 1'b0;
            end else if (w_abort) begin
                r_rsp_rdata   <= '0;
                r_rsp_slverr  <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end else if (w_misalign) begin
                r_rsp_rdata   <= '0;
                r_rsp_slverr  <= 1'b1;
                r_rsp_timeout <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.PSEL        = w_psel;
    assign bus.PENABLE     = w_penable;
    assign bus.PADDR       = r_paddr;
    assign bus.PPROT       = r_pprot;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PWDATA      = r_pwdata;
    assign bus.PSTRB       = r_pstrb;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_slverr  = r_rsp_slverr;
    assign bus.rsp_timeout = r_rsp_timeout;

    // Protocol sanity: enable only inside a selected transfer, setup always
    // followed by access, no command acceptance while the bus is busy.
    a_penable_in_psel: assert property (@(posedge PCLK) disable iff (PRESET)
        bus.PENABLE |-> bus.PSEL);

    a_setup_then_access: assert property (@(posedge PCLK) disable iff (PRESET)
        (bus.PSEL && !bus.PENABLE && !PRESET) |=> bus.PENABLE);

    a_ready_only_idle: assert property (@(posedge PCLK) disable iff (PRESET)
        bus.cmd_ready |-> !bus.PSEL);

    a_timeout_is_error: assert property (@(posedge PCLK) disable iff (PRESET)
        bus.rsp_timeout |-> bus.rsp_slverr);

endmodule
